// File: rtl/obb_pkg.sv
// Shared definitions for the oriented-bounding-box separating-axis test.
// Holds data-width/scale defaults, the 15 axis indices (plus "none"), the
// controller state encoding, and small index helpers used by the evaluator.
package obb_pkg;

    localparam int OBB_W     = 41;
    localparam int OBB_SCALE = 100;
    localparam int OBB_EPS   = 1;

    // Axis numbering: A faces, B faces, then Ai x Bj at 6 + 3*i + j
    localparam logic [3:0] AX_A0   = 4'd0;
    localparam logic [3:0] AX_A1   = 4'd1;
    localparam logic [3:0] AX_A2   = 4'd2;
    localparam logic [3:0] AX_B0   = 4'd3;
    localparam logic [3:0] AX_B1   = 4'd4;
    localparam logic [3:0] AX_B2   = 4'd5;
    localparam logic [3:0] AX_X00  = 4'd6;
    localparam logic [3:0] AX_X01  = 4'd7;
    localparam logic [3:0] AX_X02  = 4'd8;
    localparam logic [3:0] AX_X10  = 4'd9;
    localparam logic [3:0] AX_X11  = 4'd10;
    localparam logic [3:0] AX_X12  = 4'd11;
    localparam logic [3:0] AX_X20  = 4'd12;
    localparam logic [3:0] AX_X21  = 4'd13;
    localparam logic [3:0] AX_X22  = 4'd14;
    localparam logic [3:0] AX_NONE = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ABS  = 2'd1,
        ST_TEST = 2'd2,
        ST_DONE = 2'd3
    } obb_state_e;

    typedef enum logic [1:0] {
        AK_FACE_A = 2'd0,
        AK_FACE_B = 2'd1,
        AK_CROSS  = 2'd2,
        AK_NONE   = 2'd3
    } axis_kind_e;

    typedef struct packed {
        axis_kind_e  kind;
        logic [1:0]  i;
        logic [1:0]  j;
    } axis_sel_t;

    // (v + 1) mod 3
    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // (v + 2) mod 3, i.e. (v - 1) mod 3
    function automatic logic [1:0] mod3_dec(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd2;
            2'd1:    return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    // Map an axis index to its family and the (i, j) box-axis indices
    function automatic axis_sel_t decode_axis(input logic [3:0] k);
        case (k)
            AX_A0:   return '{AK_FACE_A, 2'd0, 2'd0};
            AX_A1:   return '{AK_FACE_A, 2'd1, 2'd0};
            AX_A2:   return '{AK_FACE_A, 2'd2, 2'd0};
            AX_B0:   return '{AK_FACE_B, 2'd0, 2'd0};
            AX_B1:   return '{AK_FACE_B, 2'd0, 2'd1};
            AX_B2:   return '{AK_FACE_B, 2'd0, 2'd2};
            AX_X00:  return '{AK_CROSS, 2'd0, 2'd0};
            AX_X01:  return '{AK_CROSS, 2'd0, 2'd1};
            AX_X02:  return '{AK_CROSS, 2'd0, 2'd2};
            AX_X10:  return '{AK_CROSS, 2'd1, 2'd0};
            AX_X11:  return '{AK_CROSS, 2'd1, 2'd1};
            AX_X12:  return '{AK_CROSS, 2'd1, 2'd2};
            AX_X20:  return '{AK_CROSS, 2'd2, 2'd0};
            AX_X21:  return '{AK_CROSS, 2'd2, 2'd1};
            AX_X22:  return '{AK_CROSS, 2'd2, 2'd2};
            default: return '{AK_NONE, 2'd0, 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/obb_axis_eval.sv
// Combinational evaluation of one separating-axis candidate.
// Ports:
//   k        axis index 0..14 (15 yields sep=0)
//   t        translation of B in A frame (x SCALE), signed
//   ea, eb   half-extents of A and B (x SCALE), non-negative
//   r        rotation A^T*B, row-major [i][j] (x SCALE), signed
//   ar       |r| + EPS, one bit wider than r
//   sep      1 when the projected distance strictly exceeds the projected radii
// Both sides are formed at SCALE^2 in 2W+3 bits, so no product or sum truncates.
module obb_axis_eval
    import obb_pkg::*;
#(
    parameter int W     = OBB_W,
    parameter int SCALE = OBB_SCALE
) (
    input  logic [3:0]          k,
    input  logic signed [W-1:0] t  [3],
    input  logic signed [W-1:0] ea [3],
    input  logic signed [W-1:0] eb [3],
    input  logic signed [W-1:0] r  [3][3],
    input  logic signed [W:0]   ar [3][3],
    output logic                sep
);

    localparam int SW = 2 * W + 3;

    axis_sel_t            sel_s;
    logic [1:0]           i0_s, i1_s, i2_s;
    logic [1:0]           j0_s, j1_s, j2_s;
    logic signed [SW-1:0] lhs_s;
    logic signed [SW-1:0] rhs_s;
    logic                 valid_s;

    function automatic logic signed [SW-1:0] abs_sw(input logic signed [SW-1:0] v);
        return v[SW-1] ? -v : v;
    endfunction

    // Select the axis family and form projected distance (lhs) and radii sum (rhs)
    always_comb begin
        sel_s   = decode_axis(k);
        i0_s    = sel_s.i;
        i1_s    = mod3_inc(sel_s.i);
        i2_s    = mod3_dec(sel_s.i);
        j0_s    = sel_s.j;
        j1_s    = mod3_inc(sel_s.j);
        j2_s    = mod3_dec(sel_s.j);
        lhs_s   = {SW{1'b0}};
        rhs_s   = {SW{1'b0}};
        valid_s = 1'b0;
        case (sel_s.kind)
            AK_FACE_A: begin
                lhs_s   = abs_sw(SW'(t[i0_s])) * SW'(SCALE);
                rhs_s   = SW'(ea[i0_s]) * SW'(SCALE)
                        + SW'(eb[0]) * SW'(ar[i0_s][0])
                        + SW'(eb[1]) * SW'(ar[i0_s][1])
                        + SW'(eb[2]) * SW'(ar[i0_s][2]);
                valid_s = 1'b1;
            end
            AK_FACE_B: begin
                lhs_s   = abs_sw(SW'(t[0]) * SW'(r[0][j0_s])
                               + SW'(t[1]) * SW'(r[1][j0_s])
                               + SW'(t[2]) * SW'(r[2][j0_s]));
                rhs_s   = SW'(ea[0]) * SW'(ar[0][j0_s])
                        + SW'(ea[1]) * SW'(ar[1][j0_s])
                        + SW'(ea[2]) * SW'(ar[2][j0_s])
                        + SW'(eb[j0_s]) * SW'(SCALE);
                valid_s = 1'b1;
            end
            AK_CROSS: begin
                lhs_s   = abs_sw(SW'(t[i2_s]) * SW'(r[i1_s][j0_s])
                               - SW'(t[i1_s]) * SW'(r[i2_s][j0_s]));
                rhs_s   = SW'(ea[i1_s]) * SW'(ar[i2_s][j0_s])
                        + SW'(ea[i2_s]) * SW'(ar[i1_s][j0_s])
                        + SW'(eb[j1_s]) * SW'(ar[i0_s][j2_s])
                        + SW'(eb[j2_s]) * SW'(ar[i0_s][j1_s]);
                valid_s = 1'b1;
            end
            default: begin
                lhs_s   = {SW{1'b0}};
                rhs_s   = {SW{1'b0}};
                valid_s = 1'b0;
            end
        endcase
    end

    // Strict comparison: equal sides mean touching, which is not a separation
    assign sep = valid_s && (lhs_s > rhs_s);

endmodule

// File: rtl/obb_sat_test.sv
// 15-axis separating-axis test between two oriented boxes, one axis per clock,
// stopping at the first axis that separates them.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, accepted only when idle
//   r0..r8            R = A^T*B row-major (x SCALE), signed
//   t0..t2            translation in A frame (x SCALE), signed
//   ea0..ea2/eb0..eb2 half-extents (x SCALE)
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle result strobe
//   collide           1 when no axis separated the boxes
//   sep_axis          separating axis index, 15 when none
// Flow: IDLE (latch) -> ABS (build |R|+EPS) -> TEST (k = 0..14) -> DONE -> IDLE.
module obb_sat_test
    import obb_pkg::*;
#(
    parameter int W     = OBB_W,
    parameter int SCALE = OBB_SCALE,
    parameter int EPS   = OBB_EPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8,
    input  logic signed [W-1:0] t0, t1, t2,
    input  logic signed [W-1:0] ea0, ea1, ea2,
    input  logic signed [W-1:0] eb0, eb1, eb2,
    output logic                busy,
    output logic                done,
    output logic                collide,
    output logic [3:0]          sep_axis
);

    obb_state_e          state_r;
    logic [3:0]          k_r;
    logic signed [W-1:0] t_r  [3];
    logic signed [W-1:0] ea_r [3];
    logic signed [W-1:0] eb_r [3];
    logic signed [W-1:0] r_r  [3][3];
    logic signed [W:0]   ar_r [3][3];
    logic                busy_r;
    logic                done_r;
    logic                collide_r;
    logic [3:0]          sep_axis_r;
    logic                sep_s;

    // |v| widened by one bit so that |R| + EPS never wraps
    function automatic logic signed [W:0] abs_ext(input logic signed [W-1:0] v);
        logic signed [W:0] x;
        x = (W+1)'(v);
        return x[W] ? -x : x;
    endfunction

    obb_axis_eval #(
        .W     (W),
        .SCALE (SCALE)
    ) u_eval (
        .k   (k_r),
        .t   (t_r),
        .ea  (ea_r),
        .eb  (eb_r),
        .r   (r_r),
        .ar  (ar_r),
        .sep (sep_s)
    );

    // Controller, operand latches, |R| register file and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            collide_r  <= 1'b0;
            sep_axis_r <= AX_NONE;
            for (int i = 0; i < 3; i++) begin
                t_r[i]  <= {W{1'b0}};
                ea_r[i] <= {W{1'b0}};
                eb_r[i] <= {W{1'b0}};
                for (int j = 0; j < 3; j++) begin
                    r_r[i][j]  <= {W{1'b0}};
                    ar_r[i][j] <= {(W+1){1'b0}};
                end
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        t_r        <= '{t0, t1, t2};
                        ea_r       <= '{ea0, ea1, ea2};
                        eb_r       <= '{eb0, eb1, eb2};
                        r_r        <= '{'{r0, r1, r2}, '{r3, r4, r5}, '{r6, r7, r8}};
                        busy_r     <= 1'b1;
                        collide_r  <= 1'b0;
                        sep_axis_r <= AX_NONE;
                        state_r    <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            ar_r[i][j] <= abs_ext(r_r[i][j]) + (W+1)'(EPS);
                        end
                    end
                    k_r     <= 4'd0;
                    state_r <= ST_TEST;
                end
                ST_TEST: begin
                    if (sep_s) begin
                        sep_axis_r <= k_r;
                        collide_r  <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_DONE;
                    end else if (k_r == AX_X22) begin
                        sep_axis_r <= AX_NONE;
                        collide_r  <= 1'b1;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        k_r <= k_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign collide  = collide_r;
    assign sep_axis = sep_axis_r;

endmodule

// File: tb/tb_obb_sat_test.sv
// Bench for obb_sat_test: a vector table with hand-derived expected axes, a set of
// random vectors scored by a behavioural model, and hand-written sequences for
// start-while-busy and reset-while-busy. Expected results queue up when a start is
// driven and are consumed by a monitor whenever done pulses.
module tb_obb_sat_test;

    localparam int W        = 41;
    localparam int SCALE_TB = 100;
    localparam int EPS_TB   = 0;

    typedef int arr9_t [9];
    typedef int arr3_t [3];

    typedef struct {
        string name;
        arr9_t r;
        arr3_t t;
        arr3_t ea;
        arr3_t eb;
        int    exp_axis;
    } vec_t;

    typedef struct {
        string name;
        int    axis;
        int    start_cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic signed [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;
    logic signed [W-1:0] t0, t1, t2, ea0, ea1, ea2, eb0, eb1, eb2;
    logic                busy, done, collide;
    logic [3:0]          sep_axis;

    int   tests_run = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[$];

    arr9_t ID   = '{100, 0, 0, 0, 100, 0, 0, 0, 100};
    arr9_t ROT  = '{71, -71, 0, 71, 71, 0, 0, 0, 100};
    arr9_t XR6  = '{0, 0, 0, 100, 0, 0, -100, 0, 0};
    arr9_t XR14 = '{0, 0, 100, 0, 0, -100, 0, 0, 0};
    arr3_t E100 = '{100, 100, 100};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obb_sat_test #(.W(W), .SCALE(SCALE_TB), .EPS(EPS_TB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7), .r8(r8),
        .t0(t0), .t1(t1), .t2(t2),
        .ea0(ea0), .ea1(ea1), .ea2(ea2),
        .eb0(eb0), .eb1(eb1), .eb2(eb2),
        .busy(busy), .done(done), .collide(collide), .sep_axis(sep_axis)
    );

    task automatic check(input string nm, input longint act, input longint req);
        tests_run++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input string nm, input arr9_t rr, input arr3_t tt, input int ax);
        vec_t v;
        v.name = nm; v.r = rr; v.t = tt; v.ea = E100; v.eb = E100; v.exp_axis = ax;
        return v;
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: first separating axis in test order, 15 when none
    function automatic int model_axis(input vec_t v);
        longint rm[3][3], am[3][3], tm[3], a[3], b[3], lhs, rhs;
        for (int i = 0; i < 3; i++) begin
            tm[i] = v.t[i]; a[i] = v.ea[i]; b[i] = v.eb[i];
            for (int j = 0; j < 3; j++) begin
                rm[i][j] = v.r[3*i+j];
                am[i][j] = labs(rm[i][j]) + EPS_TB;
            end
        end
        for (int i = 0; i < 3; i++) begin
            lhs = labs(tm[i]) * SCALE_TB;
            rhs = a[i] * SCALE_TB + b[0] * am[i][0] + b[1] * am[i][1] + b[2] * am[i][2];
            if (lhs > rhs) return i;
        end
        for (int j = 0; j < 3; j++) begin
            lhs = labs(tm[0] * rm[0][j] + tm[1] * rm[1][j] + tm[2] * rm[2][j]);
            rhs = a[0] * am[0][j] + a[1] * am[1][j] + a[2] * am[2][j] + b[j] * SCALE_TB;
            if (lhs > rhs) return 3 + j;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int p = (i + 1) % 3, q = (i + 2) % 3, u = (j + 1) % 3, w = (j + 2) % 3;
                lhs = labs(tm[q] * rm[p][j] - tm[p] * rm[q][j]);
                rhs = a[p] * am[q][j] + a[q] * am[p][j] + b[u] * am[i][w] + b[w] * am[i][u];
                if (lhs > rhs) return 6 + 3 * i + j;
            end
        end
        return 15;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("done_with_empty_scoreboard", longint'(sb_q.size()), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_sep_axis"}, sep_axis, mon_e.axis);
                check({mon_e.name, "_collide"}, collide, (mon_e.axis == 15) ? 1 : 0);
                check({mon_e.name, "_done_cycle"}, cyc - mon_e.start_cyc + 1,
                      (mon_e.axis == 15) ? 17 : 3 + mon_e.axis);
                check({mon_e.name, "_busy_at_done"}, busy, 0);
            end
        end
    end

    task automatic apply(input vec_t v);
        r0 = W'(v.r[0]); r1 = W'(v.r[1]); r2 = W'(v.r[2]);
        r3 = W'(v.r[3]); r4 = W'(v.r[4]); r5 = W'(v.r[5]);
        r6 = W'(v.r[6]); r7 = W'(v.r[7]); r8 = W'(v.r[8]);
        t0 = W'(v.t[0]); t1 = W'(v.t[1]); t2 = W'(v.t[2]);
        ea0 = W'(v.ea[0]); ea1 = W'(v.ea[1]); ea2 = W'(v.ea[2]);
        eb0 = W'(v.eb[0]); eb1 = W'(v.eb[1]); eb2 = W'(v.eb[2]);
    endtask

    // Drive a one-cycle start; optionally register the expected result
    task automatic launch(input vec_t v, input bit push);
        exp_t e;
        @(negedge clk);
        apply(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.name = v.name; e.axis = v.exp_axis; e.start_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int base, input string nm);
        for (int n = 0; n < 40 && done_seen <= base; n++) @(posedge clk);
        if (done_seen <= base) check({nm, "_done_timeout"}, done_seen, base + 1);
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        base = done_seen;
        launch(v, 1'b1);
        wait_done(base, v.name);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        vec_t v;
        int   base;

        tbl.push_back(mk("a0_sep",     ID,   '{500, 0, 0},     0));
        tbl.push_back(mk("a1_neg_t",   ID,   '{0, -500, 0},    1));
        tbl.push_back(mk("a2_sep",     ID,   '{0, 0, 500},     2));
        tbl.push_back(mk("inside",     ID,   '{150, 0, 0},     15));
        tbl.push_back(mk("touching",   ID,   '{200, 0, 0},     15));
        tbl.push_back(mk("just_apart", ID,   '{201, 0, 0},     0));
        tbl.push_back(mk("b0_rot",     ROT,  '{200, 200, 0},   3));
        tbl.push_back(mk("b0_rot_neg", ROT,  '{-200, -200, 0}, 3));
        tbl.push_back(mk("b1_rot",     ROT,  '{-200, 200, 0},  4));
        tbl.push_back(mk("x00_sep",    XR6,  '{0, 150, 150},   6));
        tbl.push_back(mk("x22_last",   XR14, '{150, 150, 0},   14));

        rst = 1'b1; start = 1'b0;
        apply(mk("zero", ID, '{0, 0, 0}, 15));
        repeat (3) @(posedge clk);
        // start coinciding with reset must be dropped
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_collide", collide, 0);
        check("reset_sep_axis", sep_axis, 15);
        repeat (3) @(posedge clk);
        #1;
        check("start_under_reset_ignored", busy, 0);

        foreach (tbl[n]) run_vec(tbl[n]);

        for (int n = 0; n < 30; n++) begin
            v.name = $sformatf("rand%0d", n);
            for (int m = 0; m < 9; m++) v.r[m] = int'($urandom_range(200)) - 100;
            for (int m = 0; m < 3; m++) begin
                v.t[m]  = int'($urandom_range(800)) - 400;
                v.ea[m] = int'($urandom_range(150));
                v.eb[m] = int'($urandom_range(150));
            end
            v.exp_axis = model_axis(v);
            run_vec(v);
        end

        // start while busy (cycle 5) is ignored; one done with the original result
        base = done_seen;
        launch(tbl[3], 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(base, "busy_start");
        repeat (20) @(posedge clk);
        check("busy_start_single_done", done_seen, base + 1);
        // next start after done is accepted and replaces the result
        run_vec(tbl[0]);
        repeat (3) @(negedge clk);
        check("held_sep_axis", sep_axis, 0);
        check("held_collide", collide, 0);

        // reset in cycle 8 of a collide run aborts it with no done pulse
        base = done_seen;
        launch(tbl[3], 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sep_axis", sep_axis, 15);
        check("abort_collide", collide, 0);
        repeat (20) @(posedge clk);
        check("abort_no_done", done_seen, base);
        run_vec(tbl[6]);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
